run_monitor: RTL and testbench

RUN_MONITOR -- requirements
Module: run_monitor

---
 rtl/run_monitor.sv | 224 ++++++++++++++++++++++
 tb/tb_run_monitor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_monitor.sv
// -----------------------------------------------------------------------------
// run_monitor
//   Holds a core in reset for RST_CYCLES cycles, releases it and then watches
//   its program counter. Every new PC value seen while the core runs is logged
//   into a small trace FIFO that software drains through trace_rd/trace_data.
//   The run ends in TIMEOUT after TIMEOUT_CYCLES cycles, or optionally in
//   HALTED when the PC stops moving. Both end states hold until rst or clear.
//
// Optional feature (compile-time macro):
//   RUN_MONITOR_HALT_DETECT_EN - when defined, a PC that stays unchanged for
//   HALT_CYCLES consecutive RUN cycles moves the monitor to HALTED. When not
//   defined there is no halt logic and halted is tied low.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   clear        in   synchronous restart: flush FIFO, back to HOLD
//   pc_trace     in   [PC_W]  program counter from the core
//   core_rst     out  reset driven to the core (high only in HOLD)
//   running      out  high in RUN
//   timeout      out  high in TIMEOUT
//   halted       out  high in HALTED
//   trace_rd     in   pop request (ignored when FIFO empty)
//   trace_data   out  [PC_W]  FIFO head, zero when empty
//   trace_valid  out  FIFO not empty
//   trace_count  out  [$clog2(DEPTH+1)]  entries held
//   overflow     out  sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module run_monitor #(
  parameter int PC_W           = 4,
  parameter int DEPTH          = 8,
  parameter int RST_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int HALT_CYCLES    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [PC_W-1:0]            pc_trace,
  output logic                       core_rst,
  output logic                       running,
  output logic                       timeout,
  output logic                       halted,
  input  logic                       trace_rd,
  output logic [PC_W-1:0]            trace_data,
  output logic                       trace_valid,
  output logic [$clog2(DEPTH+1)-1:0] trace_count,
  output logic                       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   run_cnt;
  logic [PC_W-1:0] last_pc;
  logic            run_first;
  logic            timeout_hit;
  logic            halt_hit;
  logic            push_req;
  logic            pop_ok;
  logic            push_ok;

  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow_q;

  assign run_first   = (run_cnt == '0);
  assign timeout_hit = (run_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef RUN_MONITOR_HALT_DETECT_EN
  localparam int SW = $clog2(HALT_CYCLES + 1);

  logic [PC_W-1:0] prev_pc;
  logic [SW-1:0]   stable_cnt;
  logic            pc_same;

  // The first RUN cycle has no meaningful previous value (it belongs to HOLD),
  // so an unchanged PC only counts from the second RUN cycle onwards.
  assign pc_same  = !run_first && (pc_trace == prev_pc);
  assign halt_hit = pc_same && (stable_cnt == SW'(HALT_CYCLES - 1));

  // Track the previous-cycle PC and how many cycles in a row it has not moved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_pc    <= '0;
      stable_cnt <= '0;
    end else begin
      prev_pc <= pc_trace;
      if (clear || (state != ST_RUN) || !pc_same) begin
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + SW'(1);
      end
    end
  end

  assign halted = (state == ST_HALTED);
`else
  assign halt_hit = 1'b0;
  // Halt detection is compiled out; the compare is always false for any
  // legal HALT_CYCLES and keeps the parameter referenced.
  assign halted   = (HALT_CYCLES < 0);
`endif

  // State register plus the HOLD/RUN cycle counters and the last logged PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_HOLD;
      hold_cnt <= '0;
      run_cnt  <= '0;
      last_pc  <= '0;
    end else begin
      state <= next_state;
      if (clear) begin
        hold_cnt <= '0;
        run_cnt  <= '0;
      end else begin
        if (state == ST_HOLD) begin
          hold_cnt <= (next_state == ST_HOLD) ? hold_cnt + HW'(1) : '0;
        end
        if (state == ST_RUN) begin
          run_cnt <= run_cnt + TW'(1);
        end
      end
      if (push_req) begin
        last_pc <= pc_trace;
      end
    end
  end

  // Next-state and push decision. Timeout is checked before halt so it wins
  // when both happen on the same cycle; clear overrides everything.
  always_comb begin
    next_state = state;
    push_req   = 1'b0;
    case (state)
      ST_HOLD: begin
        if (hold_cnt == HW'(RST_CYCLES - 1)) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        push_req = run_first || (pc_trace != last_pc);
        if (timeout_hit) begin
          next_state = ST_TIMEOUT;
        end else if (halt_hit) begin
          next_state = ST_HALTED;
        end
      end
      default: begin
      end
    endcase
    if (clear) begin
      next_state = ST_HOLD;
      push_req   = 1'b0;
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is being read.
  assign pop_ok  = trace_rd && (count != '0);
  assign push_ok = push_req && ((count != CW'(DEPTH)) || pop_ok);

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: begin
        end
      endcase
      if (push_req && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Trace storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= pc_trace;
    end
  end

  assign core_rst    = (state == ST_HOLD);
  assign running     = (state == ST_RUN);
  assign timeout     = (state == ST_TIMEOUT);
  assign trace_valid = (count != '0);
  assign trace_count = count;
  assign overflow    = overflow_q;
  assign trace_data  = trace_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_run_monitor
//   Directed and random stimulus for run_monitor. A queue-based reference
//   model tracks the monitor phase, the expected trace FIFO contents and the
//   overflow flag; every step compares all DUT outputs against it.
//   Build with RUN_MONITOR_HALT_DETECT_EN to exercise halt detection.
// -----------------------------------------------------------------------------
module tb_run_monitor;

  localparam int PC_W           = 4;
  localparam int DEPTH          = 8;
  localparam int RST_CYCLES     = 3;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int HALT_CYCLES    = 4;
  localparam int CW             = $clog2(DEPTH + 1);

  logic            clk      = 1'b0;
  logic            rst      = 1'b1;
  logic            clear    = 1'b0;
  logic            trace_rd = 1'b0;
  logic [PC_W-1:0] pc_trace = '0;
  logic            core_rst;
  logic            running;
  logic            timeout;
  logic            halted;
  logic [PC_W-1:0] trace_data;
  logic            trace_valid;
  logic [CW-1:0]   trace_count;
  logic            overflow;

  int total = 0;
  int bad   = 0;

  run_monitor #(
    .PC_W          (PC_W),
    .DEPTH         (DEPTH),
    .RST_CYCLES    (RST_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .HALT_CYCLES   (HALT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .pc_trace   (pc_trace),
    .core_rst   (core_rst),
    .running    (running),
    .timeout    (timeout),
    .halted     (halted),
    .trace_rd   (trace_rd),
    .trace_data (trace_data),
    .trace_valid(trace_valid),
    .trace_count(trace_count),
    .overflow   (overflow)
  );

  // Free-running 10ns clock.
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: phase, cycles spent in it, expected FIFO contents.
  typedef enum int {M_HOLD, M_RUN, M_TIMEOUT, M_HALTED} phase_t;
  phase_t          m_phase;
  int              m_hold;
  int              m_run;
  int              m_stable;
  bit              m_ovf;
  logic [PC_W-1:0] m_last;
  logic [PC_W-1:0] m_prev;
  logic [PC_W-1:0] q[$];

  function automatic void modelReset();
    m_phase  = M_HOLD;
    m_hold   = 0;
    m_run    = 0;
    m_stable = 0;
    m_ovf    = 1'b0;
    m_last   = '0;
    m_prev   = '0;
    q.delete();
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge.
  function automatic void modelStep(input logic c, input logic [PC_W-1:0] pc, input logic rd);
    bit do_pop;
    bit do_push;
    bit halt_seen;
    if (c) begin
      modelReset();
      return;
    end
    do_pop    = rd && (q.size() > 0);
    do_push   = 1'b0;
    halt_seen = 1'b0;
    if (m_phase == M_RUN) begin
      do_push = (m_run == 0) || (pc != m_last);
      if (do_push) m_last = pc;
    end
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      if (q.size() < DEPTH) q.push_back(pc);
      else m_ovf = 1'b1;
    end
    case (m_phase)
      M_HOLD: begin
        m_hold++;
        if (m_hold == RST_CYCLES) begin
          m_phase = M_RUN;
          m_run   = 0;
        end
      end
      M_RUN: begin
`ifdef RUN_MONITOR_HALT_DETECT_EN
        if ((m_run > 0) && (pc == m_prev)) m_stable++;
        else m_stable = 0;
        halt_seen = (m_stable == HALT_CYCLES);
`endif
        m_run++;
        if (m_run == TIMEOUT_CYCLES) m_phase = M_TIMEOUT;
        else if (halt_seen) m_phase = M_HALTED;
      end
      default: begin
      end
    endcase
    m_prev = pc;
  endfunction

  // One comparison with its own immediate assertion.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with the model.
  task automatic checkOutput(input string where);
    logic [PC_W-1:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : '0;
    chk({where, ":core_rst"},    32'(core_rst),    32'(m_phase == M_HOLD));
    chk({where, ":running"},     32'(running),     32'(m_phase == M_RUN));
    chk({where, ":timeout"},     32'(timeout),     32'(m_phase == M_TIMEOUT));
    chk({where, ":halted"},      32'(halted),      32'(m_phase == M_HALTED));
    chk({where, ":trace_valid"}, 32'(trace_valid), 32'(q.size() > 0));
    chk({where, ":trace_count"}, 32'(trace_count), 32'(q.size()));
    chk({where, ":overflow"},    32'(overflow),    32'(m_ovf));
    chk({where, ":trace_data"},  32'(trace_data),  32'(exp_data));
  endtask

  // Drive one cycle of inputs, step the model, then sample after the edge.
  task automatic applyStimulus(input logic c, input logic [PC_W-1:0] pc,
                               input logic rd, input string where);
    clear    = c;
    pc_trace = pc;
    trace_rd = rd;
    modelStep(c, pc, rd);
    @(posedge clk);
    #1;
    checkOutput(where);
  endtask

  initial begin
    logic [PC_W-1:0] pc_r;
    logic            clr_r;
    logic            rd_r;

    // Reset state while rst is held.
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    rst = 1'b0;
    #1;
    chk("hold_c1:core_rst", 32'(core_rst), 32'd1);

    // Core reset held for RST_CYCLES cycles, then RUN.
    for (int i = 0; i < RST_CYCLES; i++) applyStimulus(1'b0, '0, 1'b0, "hold");
    chk("hold_exit:running",  32'(running),  32'd1);
    chk("hold_exit:core_rst", 32'(core_rst), 32'd0);

    // Repeated PC values are logged once.
    applyStimulus(1'b0, 4'd0, 1'b0, "seq0");
    applyStimulus(1'b0, 4'd1, 1'b0, "seq1");
    applyStimulus(1'b0, 4'd1, 1'b0, "seq1b");
    applyStimulus(1'b0, 4'd2, 1'b0, "seq2");
    applyStimulus(1'b0, 4'd3, 1'b0, "seq3");
    chk("seq:count",    32'(trace_count), 32'd4);
    chk("seq:overflow", 32'(overflow),    32'd0);
    chk("seq:head",     32'(trace_data),  32'd0);

    // Drain in order, read while empty, then push+pop on empty FIFO.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'd3, 1'b1, "drain");
    applyStimulus(1'b0, 4'd3, 1'b1, "rd_empty");
    applyStimulus(1'b0, 4'd4, 1'b1, "pushpop_empty");
    chk("pushpop_empty:count", 32'(trace_count), 32'd1);
    chk("pushpop_empty:head",  32'(trace_data),  32'd4);

    // Restart and overfill with ten distinct values.
    applyStimulus(1'b1, 4'd0, 1'b0, "clear1");
    for (int i = 0; i < RST_CYCLES; i++) applyStimulus(1'b0, '0, 1'b0, "hold2");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, PC_W'(i), 1'b0, "fill");
    chk("fill:count",    32'(trace_count), 32'd8);
    chk("fill:overflow", 32'(overflow),    32'd1);
    chk("fill:head",     32'(trace_data),  32'd0);
    applyStimulus(1'b0, 4'd10, 1'b1, "full_pushpop");
    chk("full_pushpop:count", 32'(trace_count), 32'd8);
    chk("full_pushpop:head",  32'(trace_data),  32'd1);

    // Remaining RUN cycles with a moving PC, ending in TIMEOUT on cycle 20.
    for (int i = 11; i < TIMEOUT_CYCLES; i++) applyStimulus(1'b0, PC_W'(i), 1'b0, "to_run");
    chk("to:timeout",  32'(timeout),  32'd1);
    chk("to:core_rst", 32'(core_rst), 32'd0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, PC_W'(i + 5), 1'b1, "to_read");
    chk("to_read:count", 32'(trace_count), 32'd6);
    chk("to_read:head",  32'(trace_data),  32'd3);

    // Clear out of TIMEOUT with six entries stored.
    applyStimulus(1'b1, 4'd0, 1'b0, "clear_to");
    chk("clear_to:core_rst", 32'(core_rst),    32'd1);
    chk("clear_to:count",    32'(trace_count), 32'd0);
    chk("clear_to:overflow", 32'(overflow),    32'd0);

    // PC parked at 5: halts after four unchanged cycles only with the macro.
    for (int i = 0; i < RST_CYCLES; i++) applyStimulus(1'b0, '0, 1'b0, "hold3");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'd5, 1'b0, "park");
`ifdef RUN_MONITOR_HALT_DETECT_EN
    chk("park:halted", 32'(halted), 32'd1);
`else
    chk("park:halted", 32'(halted), 32'd0);
`endif
    for (int i = 5; i < TIMEOUT_CYCLES; i++) applyStimulus(1'b0, 4'd5, 1'b0, "park_rest");
    applyStimulus(1'b1, 4'd0, 1'b0, "clear_park");

    // Asynchronous reset in the middle of RUN.
    for (int i = 0; i < RST_CYCLES; i++) applyStimulus(1'b0, '0, 1'b0, "hold4");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, PC_W'(i + 2), 1'b0, "midrun");
    #1;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < RST_CYCLES + 2; i++) applyStimulus(1'b0, PC_W'(i), 1'b0, "after_rst");

    // Random PCs from a small range so repeats and overflow both occur.
    for (int i = 0; i < 400; i++) begin
      pc_r  = PC_W'($urandom_range(0, 3));
      rd_r  = ($urandom_range(0, 3) == 0);
      clr_r = ($urandom_range(0, 99) == 0) ||
              (((m_phase == M_TIMEOUT) || (m_phase == M_HALTED)) && ($urandom_range(0, 3) == 0));
      applyStimulus(clr_r, pc_r, rd_r, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
